// File: rtl/pref_issue_queue.sv
// pref_issue_queue
//   Prefetch issue queue sitting behind the stride prefetcher. Up to three
//   candidates per cycle are reduced to cache-line addresses. Candidates are
//   dropped when they repeat a lower slot, are already queued, or were issued
//   recently. Survivors go into a FIFO that issues one line request per cycle
//   over a valid/ready handshake.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   pref_addrK_i / pref_validK_i  candidate byte address / valid, K = 1..3
//   req_addr_o / req_valid_o      line-aligned request to memory side
//   req_ready_i                   memory side accepts the request
//   occupancy_o                   FIFO entry count
//   dup_cnt_o / ovf_cnt_o         saturating drop counters (redundant / no space)
module pref_issue_queue #(
  parameter int ADDR_W       = 64,
  parameter int LINE_SHIFT   = 6,
  parameter int DEPTH        = 8,
  parameter int FILT_ENTRIES = 16,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          pref_addr1_i,
  input  logic                       pref_valid1_i,
  input  logic [ADDR_W-1:0]          pref_addr2_i,
  input  logic                       pref_valid2_i,
  input  logic [ADDR_W-1:0]          pref_addr3_i,
  input  logic                       pref_valid3_i,
  output logic [ADDR_W-1:0]          req_addr_o,
  output logic                       req_valid_o,
  input  logic                       req_ready_i,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic [CNT_W-1:0]           dup_cnt_o,
  output logic [CNT_W-1:0]           ovf_cnt_o
);

  localparam int LW = ADDR_W - LINE_SHIFT;
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int FW = $clog2(FILT_ENTRIES);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // State
  logic [LW-1:0]           mem       [DEPTH];
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [OW-1:0]           occ;
  logic [LW-1:0]           filt_line [FILT_ENTRIES];
  logic [FILT_ENTRIES-1:0] filt_vld;
  logic [FW-1:0]           rr_ptr;
  logic [CNT_W-1:0]        dup_cnt, ovf_cnt;

  // Candidate decode
  logic [LW-1:0] line [3];
  logic [2:0]    cand_v;
  logic          unused_low;

  assign line[0] = pref_addr1_i[ADDR_W-1:LINE_SHIFT];
  assign line[1] = pref_addr2_i[ADDR_W-1:LINE_SHIFT];
  assign line[2] = pref_addr3_i[ADDR_W-1:LINE_SHIFT];
  assign cand_v  = {pref_valid3_i, pref_valid2_i, pref_valid1_i};
  assign unused_low = ^{pref_addr1_i[LINE_SHIFT-1:0], pref_addr2_i[LINE_SHIFT-1:0],
                        pref_addr3_i[LINE_SHIFT-1:0]};

  // Redundancy check and push placement, all against pre-edge state
  logic [DEPTH-1:0] q_vld;
  logic [2:0]       hit, redundant, push_en;
  logic [PW-1:0]    push_idx [3];
  logic [OW-1:0]    free, npush;
  logic [1:0]       n_dup, n_ovf;
  logic             pop;
  logic [PW-1:0]    ofs;

  assign pop  = (occ != '0) && req_ready_i;
  assign free = OW'(DEPTH) - occ;

  always_comb begin
    q_vld     = '0;
    hit       = '0;
    redundant = '0;
    push_en   = '0;
    npush     = '0;
    n_dup     = '0;
    n_ovf     = '0;
    ofs       = '0;
    for (int k = 0; k < 3; k++) push_idx[k] = '0;

    // An entry is live when its distance from the head is below occupancy;
    // the head stays live for matching even when it pops this cycle.
    for (int i = 0; i < DEPTH; i++) begin
      ofs      = PW'(i) - rd_ptr;
      q_vld[i] = ({1'b0, ofs} < occ);
    end

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < DEPTH; i++)
        if (q_vld[i] && mem[i] == line[k]) hit[k] = 1'b1;
      for (int f = 0; f < FILT_ENTRIES; f++)
        if (filt_vld[f] && filt_line[f] == line[k]) hit[k] = 1'b1;
      for (int j = 0; j < k; j++)
        if (cand_v[j] && line[j] == line[k]) hit[k] = 1'b1;
      redundant[k] = cand_v[k] && hit[k];
    end

    // Survivors take free slots in slot order; pop does not free space now.
    for (int k = 0; k < 3; k++) begin
      if (redundant[k]) begin
        n_dup = n_dup + 2'd1;
      end else if (cand_v[k]) begin
        if (npush < free) begin
          push_en[k]  = 1'b1;
          push_idx[k] = wr_ptr + npush[PW-1:0];
          npush       = npush + OW'(1);
        end else begin
          n_ovf = n_ovf + 2'd1;
        end
      end
    end
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      filt_vld <= '0;
      rr_ptr   <= '0;
      dup_cnt  <= '0;
      ovf_cnt  <= '0;
    end else begin
      occ     <= occ + npush - OW'(pop);
      wr_ptr  <= wr_ptr + npush[PW-1:0];
      dup_cnt <= sat_add(dup_cnt, n_dup);
      ovf_cnt <= sat_add(ovf_cnt, n_ovf);
      if (pop) begin
        rd_ptr           <= rd_ptr + 1'b1;
        filt_vld[rr_ptr] <= 1'b1;
        rr_ptr           <= (rr_ptr == FW'(FILT_ENTRIES - 1)) ? '0 : rr_ptr + 1'b1;
      end
    end
  end

  // Data storage; liveness is tracked by the control state above
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (push_en[k]) mem[push_idx[k]] <= line[k];
    if (pop) filt_line[rr_ptr] <= mem[rd_ptr];
  end

  // Outputs
  assign req_valid_o = (occ != '0);
  assign req_addr_o  = req_valid_o ? {mem[rd_ptr], {LINE_SHIFT{1'b0}}} : '0;
  assign occupancy_o = occ;
  assign dup_cnt_o   = dup_cnt;
  assign ovf_cnt_o   = ovf_cnt;

endmodule
